// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 multiplier between two
// valid/ready requesters; one operation in flight at a time (IDLE/CALC/DONE).

module combo_mult (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] res
);
  assign res = a * b;
endmodule

// Per-requester response slot: raised after CALC for the owner, dropped on handshake.
module mult_arb_rsp (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic rsp_ready,
  output logic rsp_valid,
  output logic hs
);
  assign hs = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rsp_valid <= 1'b0;
    else if (set) rsp_valid <= 1'b1;
    else if (hs)  rsp_valid <= 1'b0;
  end
endmodule

module mult_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp_res,
  output logic               busy,
  output logic [15:0]        ops_done
);
  localparam int NREQ = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                   state_q, state_d;
  opnd_t [NREQ-1:0]         req_op;
  opnd_t                    op_q;
  logic  [NREQ-1:0]         req_valid, req_ready;
  logic  [NREQ-1:0]         rsp_valid, rsp_ready, rsp_hs, rsp_set;
  logic                     grant, owner_q, last_grant_q, accept;
  logic  [2*WIDTH-1:0]      prod, res_q;
  logic  [15:0]             ops_cnt;

  assign req_valid = {req1_valid, req0_valid};
  assign req_op    = {opnd_t'{a: req1_a, b: req1_b}, opnd_t'{a: req0_a, b: req0_b}};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A lone requester always wins; contention or no requests go to the one not served last.
  always_comb begin
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant_q;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (|rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      res_q        <= '0;
      ops_cnt      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        op_q         <= req_op[grant];
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == CALC) res_q <= prod;
      if (state_q == DONE && |rsp_hs) ops_cnt <= ops_cnt + 16'd1;
    end
  end

  combo_mult u_mult (
    .a   (op_q.a),
    .b   (op_q.b),
    .res (prod)
  );

  // Only the owner's slot is ever set, so the other requester's ready is ignored.
  for (genvar n = 0; n < NREQ; n++) begin : g_rsp
    assign rsp_set[n] = (state_q == CALC) && (owner_q == 1'(n));
    mult_arb_rsp u_rsp (
      .clk       (clk),
      .rst_n     (rst_n),
      .set       (rsp_set[n]),
      .rsp_ready (rsp_ready[n]),
      .rsp_valid (rsp_valid[n]),
      .hs        (rsp_hs[n])
    );
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp_res    = res_q;
  assign busy       = (state_q != IDLE);
  assign ops_done   = ops_cnt;
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one combinational 8x8 unsigned multiplier (combo_mult, ports a, b, res) between two requesters using round-robin arbitration.
- Each requester has a valid/ready request channel (operands) and a valid/ready response channel (16-bit product).
- The block registers operands and product around the multiplier and sequences one operation at a time with a 3-state FSM.
- It sits between the lab's operand sources (switch/UART front-ends) and the result consumers (display/logging).

Parameters:
- WIDTH, 8, operand width. The product is 2*WIDTH bits. Only 8 is required to synthesise, because combo_mult is fixed at 8x8.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  request 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  request 1 accepted this cycle
- req1_a  in  WIDTH  requester 1 operand a
- req1_b  in  WIDTH  requester 1 operand b
- rsp0_valid  out  1  product available for requester 0
- rsp0_ready  in  1  requester 0 takes product
- rsp1_valid  out  1  product available for requester 1
- rsp1_ready  in  1  requester 1 takes product
- rsp_res  out  2*WIDTH  product, shared by both response channels, valid only with rspN_valid
- busy  out  1  FSM not in IDLE
- ops_done  out  16  count of completed response handshakes, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (requester 0 wins first), operand regs=0, rsp_res=0, rsp0/1_valid=0, busy=0, ops_done=0. reqN_ready=0 while in reset.
- States: IDLE, CALC, DONE.
- IDLE, grant logic (combinational):
  - Only req0_valid -> grant 0. Only req1_valid -> grant 1.
  - Both valid -> grant the requester != last_grant.
  - reqN_ready = (state==IDLE) & grant==N. Never both high.
  - ready does not wait on valid of the same channel beyond the grant rule.
- Accept edge (valid&ready): latch a_reg, b_reg, owner=N; last_grant=N; state->CALC.
- CALC (exactly 1 cycle): combo_mult(a_reg, b_reg). On edge, rsp_res <= res, rsp[owner]_valid <= 1, state->DONE.
- DONE: hold rsp_res and rsp[owner]_valid stable until rsp[owner]_ready=1. On that edge: valid->0, ops_done+1, state->IDLE.
  - rspN_ready from the non-owner is ignored.
- Latency: accept at edge t -> rspN_valid high after edge t+1. Minimum issue interval is 3 cycles (accept, calc, response handshake).
- New requests are not accepted in CALC/DONE; requesters hold valid and operands.
- Operands that change while valid is high and not yet accepted: the value present on the accept edge is used.
- Arithmetic: unsigned; 0xFF*0xFF=0xFE01 with no overflow. Zero operand -> 0.
- Reset mid-operation: the in-flight op is dropped, no response is issued, ops_done is not incremented, and the arbiter restarts with requester 0 priority.
- busy = (state != IDLE).

Test Plan:
- Reset, req0 a=5 b=16 valid, rsp0_ready=1 -> req0_ready same cycle; rsp0_valid one cycle after accept with rsp_res=80 (0x0050); ops_done=1.
- req1 a=39 b=255, rsp1_ready held 0 for 4 cycles then 1 -> rsp1_valid and rsp_res=9945 (0x26D9) stable all 4 cycles; single handshake; busy low after.
- Both requesters valid from reset: req0 (8'hFF, 8'hFF), req1 (5, 5), hold valid -> grant order 0,1,0,1; products 0xFE01, 0x0019 alternating; rsp1_valid never high for a req0 op.
- a=0 b=0, then a=5 b=1 back-to-back on req0 -> results 0 and 5; second accept no earlier than 3 cycles after the first.
- Assert rst_n=0 in CALC after accepting 16*5 -> all outputs immediately reset values; no rsp0_valid; ops_done=0; the next op (5*5) returns 25.
- Drive ops_done to 0xFFFF (force or 65535 ops) then one more handshake -> 0x0000.
